// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared constants and types for the ALU issue stage: RV32I
//                opcodes, ALU select encodings, funct7 values, the payload
//                bundle handed to EX and the skid-buffer occupancy states.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam int XLEN = 32;

   // RV32I major opcodes handled by the issue stage
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] BRANCH = 7'b1100011;

   // ALU SELECT encodings (match the RV32I funct3 of the register forms)
   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SLL  = 3'd1;
   localparam logic [2:0] ALU_SLT  = 3'd2;
   localparam logic [2:0] ALU_SLTU = 3'd3;
   localparam logic [2:0] ALU_XOR  = 3'd4;
   localparam logic [2:0] ALU_SR   = 3'd5;
   localparam logic [2:0] ALU_OR   = 3'd6;
   localparam logic [2:0] ALU_AND  = 3'd7;

   // funct7 values
   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // Bundle presented to EX; field order is the packed bit order, MSB first
   typedef struct packed {
      logic [XLEN-1:0] data1;
      logic [XLEN-1:0] data2;
      logic [2:0]      select;
      logic            rotate;
      logic [4:0]      rd;
      logic            wb_en;
      logic            is_branch;
      logic [2:0]      br_funct3;
      logic            illegal;
   } payload_t;

   localparam int PAYLOAD_W = $bits(payload_t);

   // Skid buffer occupancy
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } occ_state_t;

   // Two's-complement negation with 32-bit wrap (0 stays 0)
   function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
      return ~v + XLEN'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_stage_if
//  Description : Handshake and payload bundle of the ALU issue stage.
//                in_*  : ID -> stage (instruction offer, in_ready back)
//                out_* : stage -> EX (decoded ALU request, out_ready back)
//                modport master : the ID/EX environment around the stage
//                modport slave  : the issue stage itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_stage_if #(
   parameter int XLEN = 32
) ();

   // ID side
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_rs1_val;
   logic [XLEN-1:0] in_rs2_val;

   // EX side
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_data1;
   logic [XLEN-1:0] out_data2;
   logic [2:0]      out_select;
   logic            out_rotate;
   logic [4:0]      out_rd;
   logic            out_wb_en;
   logic            out_is_branch;
   logic [2:0]      out_br_funct3;
   logic            out_illegal;

   modport master (
      output in_valid, in_instr, in_pc, in_rs1_val, in_rs2_val, out_ready,
      input  in_ready, out_valid, out_data1, out_data2, out_select, out_rotate,
             out_rd, out_wb_en, out_is_branch, out_br_funct3, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, in_pc, in_rs1_val, in_rs2_val, out_ready,
      output in_ready, out_valid, out_data1, out_data2, out_select, out_rotate,
             out_rd, out_wb_en, out_is_branch, out_br_funct3, out_illegal
   );

endinterface
`default_nettype wire

// File: rtl/alu_issue_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_decode
//  Description : Purely combinational RV32I decode into an ALU request.
//  Ports       : instr_i   - raw instruction
//                pc_i      - instruction PC (AUIPC operand)
//                rs1_i     - rs1 register value
//                rs2_i     - rs2 register value
//                payload_o - packed payload_t bundle
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_decode
   import alu_pkg::*;
(
   input  wire [31:0]          instr_i,
   input  wire [XLEN-1:0]      pc_i,
   input  wire [XLEN-1:0]      rs1_i,
   input  wire [XLEN-1:0]      rs2_i,
   output logic [PAYLOAD_W-1:0] payload_o
);

   logic [6:0] w_opcode;
   logic [4:0] w_rd;
   logic [2:0] w_funct3;
   logic [6:0] w_funct7;
   logic [XLEN-1:0] w_imm_i;
   logic [XLEN-1:0] w_imm_u;
   logic [XLEN-1:0] w_shamt;
   payload_t   w_pl;

   assign w_opcode = instr_i[6:0];
   assign w_rd     = instr_i[11:7];
   assign w_funct3 = instr_i[14:12];
   assign w_funct7 = instr_i[31:25];
   assign w_imm_i  = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
   assign w_imm_u  = {instr_i[31:12], 12'b0};
   assign w_shamt  = {{(XLEN-5){1'b0}}, instr_i[24:20]};

   always_comb begin
      w_pl = '0;
      case (w_opcode)
         OP: begin
            w_pl.data1  = rs1_i;
            w_pl.data2  = rs2_i;
            w_pl.select = w_funct3;
            w_pl.rd     = w_rd;
            if (w_funct7 == F7_ALT) begin
               // Only SUB and SRA use the alternate funct7
               if (w_funct3 == ALU_ADD) begin
                  w_pl.data2 = twos_neg(rs2_i);
               end else if (w_funct3 == ALU_SR) begin
                  w_pl.rotate = 1'b1;
               end else begin
                  w_pl.illegal = 1'b1;
               end
            end else if (w_funct7 != F7_ZERO) begin
               w_pl.illegal = 1'b1;
            end
         end
         OP_IMM: begin
            w_pl.data1  = rs1_i;
            w_pl.data2  = w_imm_i;
            w_pl.select = w_funct3;
            w_pl.rd     = w_rd;
            if (w_funct3 == ALU_SLL) begin
               w_pl.data2  = w_shamt;
               w_pl.rotate = instr_i[30];
               if (w_funct7 != F7_ZERO) begin
                  w_pl.illegal = 1'b1;
               end
            end else if (w_funct3 == ALU_SR) begin
               w_pl.data2  = w_shamt;
               w_pl.rotate = instr_i[30];
               if ((w_funct7 != F7_ZERO) && (w_funct7 != F7_ALT)) begin
                  w_pl.illegal = 1'b1;
               end
            end
         end
         LUI: begin
            w_pl.data2 = w_imm_u;
            w_pl.rd    = w_rd;
         end
         AUIPC: begin
            w_pl.data1 = pc_i;
            w_pl.data2 = w_imm_u;
            w_pl.rd    = w_rd;
         end
         BRANCH: begin
            w_pl.is_branch = 1'b1;
            w_pl.br_funct3 = w_funct3;
            w_pl.data1     = rs1_i;
            case (w_funct3[2:1])
               // BEQ/BNE: subtract so EX can test the zero flag
               2'b00: begin
                  w_pl.select = ALU_ADD;
                  w_pl.data2  = twos_neg(rs2_i);
               end
               2'b10: begin
                  w_pl.select = ALU_SLT;
                  w_pl.data2  = rs2_i;
               end
               2'b11: begin
                  w_pl.select = ALU_SLTU;
                  w_pl.data2  = rs2_i;
               end
               default: begin
                  w_pl.illegal = 1'b1;
               end
            endcase
         end
         default: begin
            w_pl.illegal = 1'b1;
         end
      endcase

      // Branches and illegal encodings never write back; x0 is never written
      w_pl.wb_en = ~w_pl.illegal & ~w_pl.is_branch & (w_pl.rd != 5'd0);
   end

   assign payload_o = w_pl;

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_stage
//  Description : Decodes one RV32I instruction per cycle into an ALU request
//                and presents it to EX through a registered 2-entry skid
//                buffer. in_ready comes straight from a flop, so EX
//                back-pressure never reaches ID combinationally.
//  Ports       : clk_i   - clock, rising edge
//                rst_i   - asynchronous active-high reset
//                flush_i - synchronous discard of both buffered entries
//                bus     - alu_issue_stage_if.slave (ID offer / EX request)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  wire             clk_i,
   input  wire             rst_i,
   input  wire             flush_i,
   alu_issue_stage_if.slave bus
);

   logic [PAYLOAD_W-1:0] w_dec_bits;
   payload_t             w_dec;
   payload_t             out_q;
   payload_t             out_d;
   payload_t             skid_q;
   payload_t             skid_d;
   occ_state_t           state_q;
   occ_state_t           state_d;
   logic                 in_ready_q;
   logic                 in_ready_d;
   logic                 w_out_valid;
   logic                 w_accept;
   logic                 w_drain;

   alu_issue_decode u_decode (
      .instr_i   (bus.in_instr),
      .pc_i      (bus.in_pc),
      .rs1_i     (bus.in_rs1_val),
      .rs2_i     (bus.in_rs2_val),
      .payload_o (w_dec_bits)
   );

   assign w_dec       = payload_t'(w_dec_bits);
   assign w_out_valid = (state_q != ST_EMPTY);
   assign w_accept    = bus.in_valid & in_ready_q;
   assign w_drain     = w_out_valid & bus.out_ready;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
         out_q      <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         out_q      <= out_d;
         skid_q     <= skid_d;
      end
   end

   // out_q is always the oldest entry; skid_q only holds the second one
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      if (flush_i) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (w_accept) begin
                  out_d   = w_dec;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_accept && w_drain) begin
                  out_d = w_dec;
               end else if (w_accept) begin
                  skid_d  = w_dec;
                  state_d = ST_FULL;
               end else if (w_drain) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only a drain can happen
               if (w_drain) begin
                  out_d   = skid_q;
                  state_d = ST_ONE;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
      in_ready_d = (state_d != ST_FULL);
   end

   assign bus.in_ready      = in_ready_q;
   assign bus.out_valid     = w_out_valid;
   assign bus.out_data1     = out_q.data1[XLEN-1:0];
   assign bus.out_data2     = out_q.data2[XLEN-1:0];
   assign bus.out_select    = out_q.select;
   assign bus.out_rotate    = out_q.rotate;
   assign bus.out_rd        = out_q.rd;
   assign bus.out_wb_en     = out_q.wb_en;
   assign bus.out_is_branch = out_q.is_branch;
   assign bus.out_br_funct3 = out_q.br_funct3;
   assign bus.out_illegal   = out_q.illegal;

endmodule
`default_nettype wire
